z80_dma_bus_arbiter: RTL
========================

Name: z80_dma_bus_arbiter

Overview:
- Block-copy DMA controller that shares the 64 KB system memory between the tv80s CPU and a DMA engine, using the CPU's BUSRQ/BUSAK handshake.
- Sits between the CPU bus and the memory array.
- When the CPU owns the bus, CPU memory signals pass straight through. When the DMA owns it, the block drives the memory port to copy cfg_len bytes from cfg_src to cfg_dst.

Parameters:
- BURST, 16: max bytes copied per bus tenure before the bus is handed back to the CPU; 0 = unlimited.
- GAP, 4: idle cycles with busrq_n high between tenures.
- RD_WAIT, 1: extra cycles mem_rd_n is held before read data is captured.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse; starts a transfer when not busy
- cfg_src  in  16  source start address, sampled on accepted start
- cfg_dst  in  16  destination start address, sampled on accepted start
- cfg_len  in  16  byte count, sampled on accepted start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the transfer completes
- cpu_busrq_n  out  1  bus request to the CPU
- cpu_busak_n  in  1  bus acknowledge from the CPU
- cpu_a  in  16  CPU address
- cpu_do  in  8  CPU write data
- cpu_mreq_n, cpu_rd_n, cpu_wr_n  in  1 each  CPU strobes
- mem_a  out  16  memory address
- mem_do  out  8  memory write data
- mem_mreq_n, mem_rd_n, mem_wr_n  out  1 each  memory strobes
- mem_di  in  8  memory read data, valid one clock after address and rd_n are presented

Behaviour:
- Reset values: busy=0, done=0, cpu_busrq_n=1, owner=CPU.
- While owner=CPU, mem_* equal the cpu_* inputs combinationally.
- States: IDLE, REQ, RD, WR, REL, WAITGAP, FIN.
- IDLE:
  - cfg_start with cfg_len≠0: latch src/dst/len, busy=1, go to REQ.
  - cfg_start with cfg_len=0: busy stays 0, done pulses the next cycle, busrq_n never asserted.
  - cfg_start while busy=1 is ignored, with no effect on the latched configuration.
- REQ: cpu_busrq_n=0. On the first rising edge sampling cpu_busak_n=0, set owner=DMA and go to RD.
- Strobe idle levels while owner=DMA: mem_mreq_n/rd_n/wr_n=1, mem_a=src, mem_do=data register.
- RD:
  - mem_a=src, mem_mreq_n=0, mem_rd_n=0 for 1+RD_WAIT cycles.
  - On the last cycle, latch mem_di into the data register, then go to WR.
- WR:
  - Exactly 1 cycle with mem_a=dst, mem_do=data, mem_mreq_n=0, mem_wr_n=0.
  - Then src+=1, dst+=1, len-=1 (16-bit, FFFF wraps to 0000), burst_cnt+=1.
- After WR:
  - len=0: go to FIN.
  - BURST≠0 and burst_cnt=BURST: go to REL.
  - Otherwise go to RD.
- REL:
  - owner=CPU and cpu_busrq_n=1 in the same cycle.
  - Wait for cpu_busak_n=1, then WAITGAP.
- WAITGAP: count GAP cycles, clear burst_cnt, go to REQ.
- FIN:
  - owner=CPU, cpu_busrq_n=1.
  - Once cpu_busak_n=1: pulse done, busy=0, go to IDLE.
- Timing: one byte costs 2+RD_WAIT cycles while owned.
- Overlap: strictly forward byte-by-byte. If dst=src+1, the first byte is replicated.
- busak_n deasserting while owner=DMA (protocol violation): finish the current WR, then go to REL.
- Async reset mid-transfer: immediate return to reset values. The transfer is lost and no done pulse is issued.
- cpu_* strobes during DMA ownership are not forwarded to memory.

Test Plan:
- Basic copy: mem[1000..1003]=11,22,33,44; start src=1000 dst=2000 len=4; bench busak_n follows busrq_n after 3 cycles -> mem[2000..2003]=11,22,33,44, exactly 4 wr pulses, one done pulse, busy low afterward.
- len=0: start src=0 dst=10 len=0 -> done one cycle later, busrq_n stays 1, memory unchanged.
- Burst split: BURST=16 GAP=4, len=40 -> three bus tenures of 16, 16 and 8 bytes; busrq_n high for ≥4 cycles between tenures; all 40 bytes correct.
- Wrap: src=FFFE dst=0100 len=4, mem[FFFE]=AA, mem[FFFF]=BB, mem[0000]=CC, mem[0001]=DD -> mem[0100..0103]=AA,BB,CC,DD.
- Passthrough under real CPU: tv80s running the fdcb0d sequence (mem[fe3e]=1b -> 8d) alongside a DMA of len=8 -> CPU result and DMA copy both correct; no mem writes outside the target ranges.
- Reset mid-op: assert reset_n=0 during the third RD -> busrq_n=1 and busy=0 immediately; only bytes 0-1 written; no done pulse.

Source files
------------

// File: rtl/z80_dma_bus_arbiter.sv
// Block-copy DMA engine sharing the 64 KB memory with a Z80 CPU through the
// BUSRQ/BUSAK handshake. CPU accesses pass straight through while it owns
// the bus; during DMA tenure the engine copies one byte per RD/WR pair.
module z80_dma_bus_arbiter #(
   parameter int BURST   = 16,  // bytes per tenure, 0 = unlimited
   parameter int GAP     = 4,   // idle cycles with busrq_n high between tenures
   parameter int RD_WAIT = 1    // extra read cycles before mem_di is captured
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_start,
   input  logic [15:0] cfg_src,
   input  logic [15:0] cfg_dst,
   input  logic [15:0] cfg_len,
   output logic        busy,
   output logic        done,
   output logic        cpu_busrq_n,
   input  logic        cpu_busak_n,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_do,
   input  logic        cpu_mreq_n,
   input  logic        cpu_rd_n,
   input  logic        cpu_wr_n,
   output logic [15:0] mem_a,
   output logic [7:0]  mem_do,
   output logic        mem_mreq_n,
   output logic        mem_rd_n,
   output logic        mem_wr_n,
   input  logic [7:0]  mem_di
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_RD, S_WR, S_REL, S_WAITGAP, S_FIN
   } state_t;

   localparam logic [15:0] BURST_N  = 16'(BURST);
   localparam logic [15:0] GAP_LAST = (GAP > 0) ? 16'(GAP - 1) : 16'd0;
   localparam logic [7:0]  RD_LAST  = 8'(RD_WAIT);

   state_t      r_state, w_next;
   logic [15:0] r_src, r_dst, r_len;
   logic [15:0] r_burst_cnt, r_gap_cnt;
   logic [7:0]  r_rd_cnt;
   logic [7:0]  r_data;
   logic        r_busy, r_done;
   logic        r_abort;   // CPU dropped busak_n while we owned the bus
   logic        w_owner_dma, w_busrq_n;
   logic [15:0] w_len_dec, w_burst_inc;

   assign w_len_dec   = r_len - 16'd1;
   assign w_burst_inc = r_burst_cnt + 16'd1;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state, bus ownership and bus request
   always_comb begin
      w_next      = r_state;
      w_owner_dma = 1'b0;
      w_busrq_n   = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (cfg_start && (cfg_len != 16'd0)) w_next = S_REQ;
         end
         S_REQ: begin
            w_busrq_n = 1'b0;
            if (!cpu_busak_n) w_next = S_RD;
         end
         S_RD: begin
            w_busrq_n   = 1'b0;
            w_owner_dma = 1'b1;
            if (r_rd_cnt == RD_LAST) w_next = S_WR;
         end
         S_WR: begin
            w_busrq_n   = 1'b0;
            w_owner_dma = 1'b1;
            if (w_len_dec == 16'd0)
               w_next = S_FIN;
            else if (r_abort || cpu_busak_n ||
                     ((BURST != 0) && (w_burst_inc == BURST_N)))
               w_next = S_REL;
            else
               w_next = S_RD;
         end
         S_REL: begin
            if (cpu_busak_n) w_next = S_WAITGAP;
         end
         S_WAITGAP: begin
            if (r_gap_cnt >= GAP_LAST) w_next = S_REQ;
         end
         S_FIN: begin
            if (cpu_busak_n) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Memory port mux: CPU passthrough unless the DMA owns the bus
   always_comb begin
      mem_a      = cpu_a;
      mem_do     = cpu_do;
      mem_mreq_n = cpu_mreq_n;
      mem_rd_n   = cpu_rd_n;
      mem_wr_n   = cpu_wr_n;
      if (w_owner_dma) begin
         mem_a      = r_src;
         mem_do     = r_data;
         mem_mreq_n = 1'b1;
         mem_rd_n   = 1'b1;
         mem_wr_n   = 1'b1;
         if (r_state == S_RD) begin
            mem_mreq_n = 1'b0;
            mem_rd_n   = 1'b0;
         end else begin
            mem_a      = r_dst;
            mem_mreq_n = 1'b0;
            mem_wr_n   = 1'b0;
         end
      end
   end

   // Transfer datapath: addresses, count, data, timers, busy/done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_src       <= '0;
         r_dst       <= '0;
         r_len       <= '0;
         r_burst_cnt <= '0;
         r_gap_cnt   <= '0;
         r_rd_cnt    <= '0;
         r_data      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_abort     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cfg_start) begin
                  if (cfg_len != 16'd0) begin
                     r_src       <= cfg_src;
                     r_dst       <= cfg_dst;
                     r_len       <= cfg_len;
                     r_burst_cnt <= '0;
                     r_busy      <= 1'b1;
                  end else begin
                     // zero-length request completes without touching the bus
                     r_done <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               r_rd_cnt <= '0;
               r_abort  <= 1'b0;
            end
            S_RD: begin
               if (cpu_busak_n) r_abort <= 1'b1;
               if (r_rd_cnt == RD_LAST) begin
                  r_data   <= mem_di;
                  r_rd_cnt <= '0;
               end else begin
                  r_rd_cnt <= r_rd_cnt + 8'd1;
               end
            end
            S_WR: begin
               r_src       <= r_src + 16'd1;
               r_dst       <= r_dst + 16'd1;
               r_len       <= w_len_dec;
               r_burst_cnt <= w_burst_inc;
               r_rd_cnt    <= '0;
            end
            S_REL: begin
               r_gap_cnt <= '0;
            end
            S_WAITGAP: begin
               r_gap_cnt   <= r_gap_cnt + 16'd1;
               r_burst_cnt <= '0;
            end
            S_FIN: begin
               if (cpu_busak_n) begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign cpu_busrq_n = w_busrq_n;

endmodule
